// File: rtl/inference_pkg.sv
// Shared types for the inference sequencer: controller states, activation
// modes and the leaky-ReLU shift amount.
package inference_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_W,
    INFER,
    DRAIN
  } state_t;

  typedef enum logic [1:0] {
    ACT_NONE,
    ACT_RELU,
    ACT_CLIP,
    ACT_LEAKY
  } act_mode_t;

  localparam int LEAKY_SHIFT = 3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty/count. The read port shows the head entry
// combinationally and reads as zero while the FIFO is empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
  assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

  // A pop frees the slot first, so a push into a full FIFO is accepted when paired with a pop.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/inference_sequencer.sv
// Sequences weight rows and buffered input vectors into a systolic array, then
// bias-adds, activates and buffers the returning results.
module inference_sequencer
  import inference_pkg::*;
#(
  parameter int LANES = 8,
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                load_weights,
  input  logic                load_weights_en,
  input  logic [LANES*DW-1:0] weight_in,
  input  logic                load_inputs_en,
  input  logic [LANES*DW-1:0] input_in,
  input  logic                start_inference,
  input  logic [LANES*DW-1:0] bias_vec,
  input  logic [1:0]          activation_mode,
  input  logic                output_ack,
  output logic                arr_w_valid,
  output logic [LANES*DW-1:0] arr_w,
  output logic                arr_in_valid,
  output logic [LANES*DW-1:0] arr_in,
  input  logic                arr_out_valid,
  input  logic [LANES*DW-1:0] arr_out,
  output logic                controller_busy,
  output logic                weights_done,
  output logic                inputs_done,
  output logic                data_ready,
  output logic [LANES*DW-1:0] output_reg,
  output logic                occupancy_err
);

  localparam int W  = LANES * DW;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int RW = $clog2(LANES + 1);
  localparam logic [DW:0] CLIP_HI = (DW+1)'(1) << (DW - 2);

  state_t          r_state;
  state_t          w_next_state;
  logic [RW-1:0]   r_row_cnt;
  logic            r_weights_done;
  logic            r_arr_w_valid;
  logic [W-1:0]    r_arr_w;
  logic            r_arr_in_valid;
  logic [W-1:0]    r_arr_in;
  logic            r_inputs_done;
  logic            r_err;
  logic [CW-1:0]   r_in_flight;
  logic            r_pp_valid;
  logic [W-1:0]    r_pp_data;

  logic            w_in_push;
  logic            w_in_accept;
  logic            w_in_pop;
  logic            w_in_full;
  logic            w_in_empty;
  logic [CW-1:0]   w_in_count;
  logic [W-1:0]    w_in_rdata;
  logic            w_out_pop;
  logic            w_out_full;
  logic            w_out_empty;
  logic [CW-1:0]   w_out_count;
  logic [W-1:0]    w_out_rdata;
  logic            w_inputs_ok;
  logic            w_load_w_ok;
  logic            w_last_row;
  logic            w_start_accept;
  logic            w_res_ok;
  logic            w_err_set;
  logic [CW:0]     w_occupancy;
  logic [W-1:0]    w_pp;
  act_mode_t       w_mode;

  assign w_mode      = act_mode_t'(activation_mode);
  assign w_inputs_ok = (r_state == IDLE) || (r_state == LOAD_W);
  assign w_load_w_ok = (r_state == LOAD_W) && load_weights_en;
  assign w_last_row  = w_load_w_ok && (r_row_cnt == RW'(LANES - 1));
  assign w_start_accept = (r_state == IDLE) && start_inference && !load_weights &&
                          r_weights_done && !w_in_empty;
  assign w_res_ok    = arr_out_valid && (r_in_flight != '0);

  // Every issued vector and every result still in the pipeline reserves an output slot.
  assign w_occupancy = (CW+1)'(r_in_flight) + (CW+1)'(w_out_count) + (CW+1)'(r_pp_valid);
  assign w_in_pop    = (r_state == INFER) && !w_in_empty && (w_occupancy < (CW+1)'(DEPTH));
  assign w_in_push   = load_inputs_en && w_inputs_ok;
  assign w_in_accept = w_in_push && (!w_in_full || w_in_pop);
  assign w_out_pop   = output_ack && !w_out_empty;

  assign w_err_set = (w_in_push && !w_in_accept)
                   | (load_inputs_en && !w_inputs_ok)
                   | (load_weights_en && (r_state != LOAD_W))
                   | (start_inference && !w_start_accept)
                   | (load_weights && (r_state != IDLE))
                   | (arr_out_valid && (r_in_flight == '0))
                   | (r_pp_valid && w_out_full && !w_out_pop);

  sync_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_in_fifo (
    .i_clk   (clk),
    .i_rst   (n_rst),
    .i_push  (w_in_push),
    .i_wdata (input_in),
    .i_pop   (w_in_pop),
    .o_rdata (w_in_rdata),
    .o_full  (w_in_full),
    .o_empty (w_in_empty),
    .o_count (w_in_count)
  );

  sync_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_out_fifo (
    .i_clk   (clk),
    .i_rst   (n_rst),
    .i_push  (r_pp_valid),
    .i_wdata (r_pp_data),
    .i_pop   (output_ack),
    .o_rdata (w_out_rdata),
    .o_full  (w_out_full),
    .o_empty (w_out_empty),
    .o_count (w_out_count)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (load_weights)        w_next_state = LOAD_W;
        else if (w_start_accept) w_next_state = INFER;
      end
      LOAD_W: if (w_last_row)           w_next_state = IDLE;
      INFER:  if (w_in_empty)           w_next_state = DRAIN;
      DRAIN:  if (r_in_flight == '0)    w_next_state = IDLE;
      default:                          w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      r_state        <= IDLE;
      r_row_cnt      <= '0;
      r_weights_done <= 1'b0;
      r_arr_w_valid  <= 1'b0;
      r_arr_w        <= '0;
      r_arr_in_valid <= 1'b0;
      r_arr_in       <= '0;
      r_inputs_done  <= 1'b0;
      r_err          <= 1'b0;
      r_in_flight    <= '0;
      r_pp_valid     <= 1'b0;
      r_pp_data      <= '0;
    end else begin
      r_state       <= w_next_state;
      r_arr_w_valid <= w_load_w_ok;
      if (w_load_w_ok) r_arr_w <= weight_in;
      if ((r_state == IDLE) && load_weights) begin
        r_row_cnt      <= '0;
        r_weights_done <= 1'b0;
      end else if (w_load_w_ok) begin
        r_row_cnt <= r_row_cnt + RW'(1);
        if (w_last_row) r_weights_done <= 1'b1;
      end
      r_arr_in_valid <= w_in_pop;
      if (w_in_pop) r_arr_in <= w_in_rdata;
      r_inputs_done <= w_in_accept && !w_in_pop && (w_in_count == CW'(DEPTH - 1));
      r_in_flight   <= r_in_flight + CW'(w_in_pop) - CW'(w_res_ok);
      r_pp_valid    <= w_res_ok;
      if (w_res_ok) r_pp_data <= w_pp;
      if (w_err_set) r_err <= 1'b1;
      else if ((r_state == IDLE) && load_weights) r_err <= 1'b0;
    end
  end

  // Overflow shows up as the top two bits of the widened sum disagreeing.
  function automatic logic [DW-1:0] sat(input logic [DW:0] v);
    if (v[DW] != v[DW-1]) return v[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    return v[DW-1:0];
  endfunction

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic        [DW-1:0] w_a;
    logic        [DW-1:0] w_b;
    logic signed [DW:0]   w_sum;
    logic signed [DW:0]   w_leaky;
    logic        [DW-1:0] w_res;

    assign w_a     = arr_out[g*DW +: DW];
    assign w_b     = bias_vec[g*DW +: DW];
    assign w_sum   = $signed({w_a[DW-1], w_a}) + $signed({w_b[DW-1], w_b});
    assign w_leaky = w_sum >>> LEAKY_SHIFT;

    always_comb begin
      w_res = '0;
      case (w_mode)
        ACT_NONE:  w_res = sat(w_sum);
        ACT_RELU:  w_res = w_sum[DW] ? '0 : sat(w_sum);
        ACT_CLIP:  w_res = w_sum[DW] ? '0 :
                           (($unsigned(w_sum) > CLIP_HI) ? CLIP_HI[DW-1:0] : w_sum[DW-1:0]);
        ACT_LEAKY: w_res = w_sum[DW] ? sat(w_leaky) : sat(w_sum);
        default:   w_res = sat(w_sum);
      endcase
    end

    assign w_pp[g*DW +: DW] = w_res;
  end

  assign arr_w_valid     = r_arr_w_valid;
  assign arr_w           = r_arr_w;
  assign arr_in_valid    = r_arr_in_valid;
  assign arr_in          = r_arr_in;
  assign controller_busy = (r_state != IDLE);
  assign weights_done    = r_weights_done;
  assign inputs_done     = r_inputs_done;
  assign data_ready      = !w_out_empty;
  assign output_reg      = w_out_rdata;
  assign occupancy_err   = r_err;

endmodule

// File: tb/tb_inference_sequencer.sv
// Scoreboard bench for inference_sequencer with a fixed-latency echo array model
// (LANES=4, DW=8, DEPTH=4).
module tb_inference_sequencer;

  localparam int LANES = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int W     = LANES * DW;
  localparam int LAT   = 5;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         load_weights;
  logic         load_weights_en;
  logic [W-1:0] weight_in;
  logic         load_inputs_en;
  logic [W-1:0] input_in;
  logic         start_inference;
  logic [W-1:0] bias_vec;
  logic [1:0]   activation_mode;
  logic         output_ack;
  logic         arr_w_valid;
  logic [W-1:0] arr_w;
  logic         arr_in_valid;
  logic [W-1:0] arr_in;
  logic         arr_out_valid;
  logic [W-1:0] arr_out;
  logic         controller_busy;
  logic         weights_done;
  logic         inputs_done;
  logic         data_ready;
  logic [W-1:0] output_reg;
  logic         occupancy_err;

  int           nChecks = 0;
  int           nFail   = 0;
  int           cyc     = 0;
  int           issued  = 0;
  int           doneCnt = 0;
  int           firstDr = -1;
  int           issueCyc[$];
  logic [W-1:0] expQ[$];
  logic [W-1:0] lastOut;

  inference_sequencer #(.LANES(LANES), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .load_weights    (load_weights),
    .load_weights_en (load_weights_en),
    .weight_in       (weight_in),
    .load_inputs_en  (load_inputs_en),
    .input_in        (input_in),
    .start_inference (start_inference),
    .bias_vec        (bias_vec),
    .activation_mode (activation_mode),
    .output_ack      (output_ack),
    .arr_w_valid     (arr_w_valid),
    .arr_w           (arr_w),
    .arr_in_valid    (arr_in_valid),
    .arr_in          (arr_in),
    .arr_out_valid   (arr_out_valid),
    .arr_out         (arr_out),
    .controller_busy (controller_busy),
    .weights_done    (weights_done),
    .inputs_done     (inputs_done),
    .data_ready      (data_ready),
    .output_reg      (output_reg),
    .occupancy_err   (occupancy_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Echo array: the vector issued in cycle c comes back in cycle c+LAT.
  initial begin
    logic [W:0] pipe [LAT+1];
    for (int i = 0; i <= LAT; i++) pipe[i] = '0;
    arr_out_valid = 1'b0;
    arr_out       = '0;
    forever begin
      @(posedge clk);
      #1;
      if (n_rst) begin
        for (int i = 0; i <= LAT; i++) pipe[i] = '0;
      end else begin
        for (int i = LAT; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = {arr_in_valid, arr_in};
      end
      arr_out_valid = pipe[LAT][W];
      arr_out       = pipe[LAT][W-1:0];
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (arr_in_valid) begin
        issued++;
        issueCyc.push_back(cyc);
      end
      if (inputs_done) doneCnt++;
      if (data_ready && firstDr < 0) firstDr = cyc;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [W-1:0] expWord(input logic [W-1:0] v, input logic [W-1:0] b, input int m);
    logic [W-1:0] r;
    int a, bb, s, x;
    int maxV, minV, clipV;
    maxV  = 2**(DW-1) - 1;
    minV  = -(2**(DW-1));
    clipV = 2**(DW-2);
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      a  = int'($signed(v[i*DW +: DW]));
      bb = int'($signed(b[i*DW +: DW]));
      s  = a + bb;
      case (m)
        1:       x = (s < 0) ? 0 : s;
        2:       x = (s < 0) ? 0 : ((s > clipV) ? clipV : s);
        3:       x = (s < 0) ? (s >>> 3) : s;
        default: x = s;
      endcase
      if (x > maxV) x = maxV;
      if (x < minV) x = minV;
      r[i*DW +: DW] = x[DW-1:0];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    n_rst = 1'b1;
    tick();
    tick();
    n_rst = 1'b0;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_busy"},    controller_busy, 0);
    checkOutput({tag, "_wdone"},   weights_done, 0);
    checkOutput({tag, "_ready"},   data_ready, 0);
    checkOutput({tag, "_outreg"},  output_reg, 0);
    checkOutput({tag, "_err"},     occupancy_err, 0);
    checkOutput({tag, "_wvalid"},  arr_w_valid, 0);
    checkOutput({tag, "_arrw"},    arr_w, 0);
    checkOutput({tag, "_invalid"}, arr_in_valid, 0);
    checkOutput({tag, "_arrin"},   arr_in, 0);
    checkOutput({tag, "_idone"},   inputs_done, 0);
  endtask

  task automatic applyStimulus(input logic [W-1:0] vec, input bit accepted);
    input_in       = vec;
    load_inputs_en = 1'b1;
    if (accepted) expQ.push_back(expWord(vec, bias_vec, int'(activation_mode)));
    tick();
    load_inputs_en = 1'b0;
  endtask

  task automatic loadWeights();
    logic [W-1:0] row;
    load_weights = 1'b1;
    tick();
    load_weights = 1'b0;
    checkOutput("lw_busy", controller_busy, 1);
    checkOutput("lw_err_cleared", occupancy_err, 0);
    checkOutput("lw_wdone_cleared", weights_done, 0);
    for (int r = 0; r < LANES; r++) begin
      row = W'($urandom);
      weight_in = row;
      load_weights_en = 1'b1;
      tick();
      checkOutput("arr_w_valid", arr_w_valid, 1);
      checkOutput("arr_w_echo", arr_w, row);
      checkOutput("weights_done_row", weights_done, (r == LANES - 1) ? 1 : 0);
    end
    load_weights_en = 1'b0;
    tick();
    checkOutput("arr_w_valid_low", arr_w_valid, 0);
    checkOutput("lw_idle", controller_busy, 0);
  endtask

  task automatic startInf();
    start_inference = 1'b1;
    tick();
    start_inference = 1'b0;
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 300 && controller_busy; i++) tick();
    checkOutput("idle_timeout", controller_busy, 0);
  endtask

  task automatic drainOne();
    for (int i = 0; i < 100 && !data_ready; i++) tick();
    checkOutput("ready_timeout", data_ready, 1);
    if (data_ready) begin
      lastOut = output_reg;
      if (expQ.size() == 0) begin
        nChecks++;
        nFail++;
        $display("[TB] FAIL sb_underflow: got %0h expected none", output_reg);
      end else begin
        checkOutput("sb_result", output_reg, expQ.pop_front());
      end
      output_ack = 1'b1;
      tick();
      output_ack = 1'b0;
    end
  endtask

  initial begin
    logic [W-1:0] modeExp [4];
    modeExp[0] = 32'h7FD87F80;
    modeExp[1] = 32'h7F007F00;
    modeExp[2] = 32'h40004000;
    modeExp[3] = 32'h7FFB7FED;

    n_rst = 1'b1;
    load_weights = 1'b0;
    load_weights_en = 1'b0;
    weight_in = '0;
    load_inputs_en = 1'b0;
    input_in = '0;
    start_inference = 1'b0;
    bias_vec = '0;
    activation_mode = 2'd0;
    output_ack = 1'b0;

    applyReset();
    checkIdle("reset");

    // Weight loading and the over-count error.
    loadWeights();
    load_weights_en = 1'b1;
    weight_in = 32'hDEADBEEF;
    tick();
    load_weights_en = 1'b0;
    checkOutput("extra_row_err", occupancy_err, 1);
    checkOutput("extra_row_not_fwd", arr_w_valid, 0);

    // Three vectors through the 5-cycle array.
    loadWeights();
    for (int i = 0; i < 3; i++) applyStimulus(W'($urandom), 1'b1);
    issueCyc.delete();
    firstDr = -1;
    startInf();
    waitIdle();
    checkOutput("issue_count", issueCyc.size(), 3);
    if (issueCyc.size() >= 3) begin
      checkOutput("issue_b2b_1", issueCyc[1] - issueCyc[0], 1);
      checkOutput("issue_b2b_2", issueCyc[2] - issueCyc[1], 1);
      checkOutput("ready_latency", firstDr - issueCyc[0], 7);
    end
    for (int i = 0; i < 3; i++) drainOne();
    checkOutput("ready_low_after", data_ready, 0);
    checkOutput("no_err_normal", occupancy_err, 0);

    // Bias add and every activation mode.
    bias_vec = {8'h32, 8'h00, 8'h14, 8'hCE};
    for (int m = 0; m < 4; m++) begin
      activation_mode = 2'(m);
      applyStimulus({8'h64, 8'hD8, 8'h78, 8'h9C}, 1'b1);
      startInf();
      waitIdle();
      drainOne();
      checkOutput("mode_word", lastOut, modeExp[m]);
    end
    bias_vec = '0;
    activation_mode = 2'd0;

    // Fill the input FIFO and push one too many.
    loadWeights();
    doneCnt = 0;
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(W'($urandom), i < DEPTH);
    tick();
    checkOutput("inputs_done_pulses", doneCnt, 1);
    checkOutput("overfill_err", occupancy_err, 1);
    startInf();
    waitIdle();
    for (int i = 0; i < DEPTH; i++) drainOne();
    checkOutput("exactly_depth_results", data_ready, 0);

    // Output back-pressure throttles issue to one vector per ack.
    loadWeights();
    issued = 0;
    for (int i = 0; i < DEPTH; i++) applyStimulus(W'($urandom), 1'b1);
    startInf();
    waitIdle();
    checkOutput("batch_a_issued", issued, DEPTH);
    for (int i = 0; i < DEPTH; i++) applyStimulus(W'($urandom), 1'b1);
    issued = 0;
    startInf();
    repeat (20) tick();
    checkOutput("stall_no_issue", issued, 0);
    checkOutput("stall_busy", controller_busy, 1);
    for (int k = 1; k <= DEPTH; k++) begin
      drainOne();
      repeat (12) tick();
      checkOutput("resume_per_ack", issued, k);
    end
    waitIdle();
    for (int i = 0; i < DEPTH; i++) drainOne();
    checkOutput("stall_drained", data_ready, 0);
    checkOutput("stall_no_err", occupancy_err, 0);

    // Reset in the middle of inference.
    loadWeights();
    for (int i = 0; i < 3; i++) applyStimulus(W'($urandom), 1'b1);
    startInf();
    tick();
    tick();
    checkOutput("mid_busy", controller_busy, 1);
    n_rst = 1'b1;
    tick();
    checkIdle("rst_mid");
    tick();
    n_rst = 1'b0;
    expQ.delete();
    repeat (10) tick();
    checkOutput("post_rst_ready", data_ready, 0);
    checkOutput("post_rst_err", occupancy_err, 0);
    loadWeights();
    startInf();
    checkOutput("empty_fifo_refused", occupancy_err, 1);
    checkOutput("empty_fifo_idle", controller_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
    $finish;
  end

endmodule
